// File: rtl/taxi_axil_regfile_pkg.sv
// Shared definitions for the AXI-Lite control/status register file.
// Build option: define TAXI_AXIL_REGFILE_ERR_EN to answer RO-region writes and
// unmapped accesses with SLVERR; otherwise every access answers OKAY.
package taxi_axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef TAXI_AXIL_REGFILE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    REGION_RW,
    REGION_RO,
    REGION_UNMAP
  } region_e;

  // Word index to address region: RW bank first, RO words after it.
  function automatic region_e decode_region(input logic [63:0] idx,
                                            input int reg_cnt,
                                            input int ro_cnt);
    if (idx < 64'(reg_cnt)) begin
      return REGION_RW;
    end else if (idx < 64'(reg_cnt) + 64'(ro_cnt)) begin
      return REGION_RO;
    end
    return REGION_UNMAP;
  endfunction

  // Writes are legal only in the RW bank; reads are legal in RW and RO.
  function automatic logic [1:0] access_resp(input region_e region,
                                             input logic is_write);
    logic legal;
    legal = is_write ? (region == REGION_RW) : (region != REGION_UNMAP);
    return (ERR_EN && !legal) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI-Lite interface bundle with separate write and read modports.
interface taxi_axil_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int AWUSER_W = 1,
  parameter int WUSER_W  = 1,
  parameter int BUSER_W  = 1,
  parameter int ARUSER_W = 1,
  parameter int RUSER_W  = 1
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic [AWUSER_W-1:0] awuser;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic [WUSER_W-1:0]  wuser;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic [BUSER_W-1:0]  buser;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport wr_mst (output awaddr, awprot, awuser, awvalid, input awready,
                  output wdata, wstrb, wuser, wvalid, input wready,
                  input bresp, buser, bvalid, output bready);
  modport wr_slv (input awaddr, awprot, awuser, awvalid, output awready,
                  input wdata, wstrb, wuser, wvalid, output wready,
                  output bresp, buser, bvalid, input bready);
  modport rd_mst (output araddr, arprot, aruser, arvalid, input arready,
                  input rdata, rresp, ruser, rvalid, output rready);
  modport rd_slv (input araddr, arprot, aruser, arvalid, output arready,
                  output rdata, rresp, ruser, rvalid, input rready);
endinterface

// File: rtl/taxi_axil_regfile_wr_join.sv
// Write-side join: one-entry AW and W holding registers, commit when both are
// present and the B slot is free, and the registered B response.
module taxi_axil_regfile_wr_join
  import taxi_axil_regfile_pkg::*;
#(
  parameter int REG_CNT = 8,
  parameter int RO_CNT  = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int STRB_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  taxi_axil_if.wr_slv       s_axil_wr,
  output logic              commit_o,
  output logic [ADDR_W-1:0] commit_idx_o,
  output logic [DATA_W-1:0] commit_data_o,
  output logic [STRB_W-1:0] commit_strb_o
);
  localparam int SHIFT = $clog2(STRB_W);

  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              w_held_q, w_held_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ADDR_W-1:0] idx;
  region_e           region;
  logic              unused_wr;

  assign idx    = awaddr_q >> SHIFT;
  assign region = decode_region(64'(idx), REG_CNT, RO_CNT);

  // A full B slot only blocks commit if the master is not taking it this cycle.
  assign commit_o = aw_held_q && w_held_q && (!bvalid_q || s_axil_wr.bready);

  // Next-state for holding registers and the B channel.
  always_comb begin
    // NOTE: every _d gets its current value first so no path leaves it unassigned (no latch).
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (s_axil_wr.awvalid && !aw_held_q) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axil_wr.awaddr;
    end
    if (s_axil_wr.wvalid && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wr.wdata;
      wstrb_d  = s_axil_wr.wstrb;
    end
    if (s_axil_wr.bready) begin
      bvalid_d = 1'b0;
    end
    if (commit_o) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = access_resp(region, 1'b1);
    end
  end

  // Write-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: blocking (=) only in always_comb, non-blocking (<=) only in always_ff.
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign s_axil_wr.awready = !aw_held_q;
  assign s_axil_wr.wready  = !w_held_q;
  assign s_axil_wr.bvalid  = bvalid_q;
  assign s_axil_wr.bresp   = bresp_q;
  assign s_axil_wr.buser   = '0;

  assign commit_idx_o  = idx;
  assign commit_data_o = wdata_q;
  assign commit_strb_o = wstrb_q;

  // Protection and user sidebands carry no meaning for this endpoint.
  assign unused_wr = ^{s_axil_wr.awprot, s_axil_wr.awuser, s_axil_wr.wuser};

endmodule

// File: rtl/taxi_axil_regfile.sv
// AXI-Lite register file: REG_CNT byte-writable RW words followed by RO_CNT
// live status words. Read path and register bank live here; the write join is
// a sub-module. DATA_W must match the DATA_W of the attached interfaces.
module taxi_axil_regfile
  import taxi_axil_regfile_pkg::*;
#(
  parameter int                        REG_CNT = 8,
  parameter int                        RO_CNT  = 4,
  parameter int                        DATA_W  = 32,
  parameter logic [REG_CNT*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  taxi_axil_if.wr_slv                s_axil_wr,
  taxi_axil_if.rd_slv                s_axil_rd,
  output logic [REG_CNT*DATA_W-1:0]  reg_q,
  output logic [REG_CNT-1:0]         wr_pulse,
  input  logic [RO_CNT*DATA_W-1:0]   ro_in
);
  localparam int ADDR_W    = s_axil_wr.ADDR_W;
  localparam int RD_ADDR_W = s_axil_rd.ADDR_W;
  localparam int STRB_W    = s_axil_wr.STRB_W;
  localparam int SHIFT     = $clog2(STRB_W);

  logic              commit;
  logic [ADDR_W-1:0] commit_idx;
  logic [DATA_W-1:0] commit_data;
  logic [STRB_W-1:0] commit_strb;
  region_e           wr_region;

  logic [DATA_W-1:0]  bank_q [REG_CNT];
  logic [DATA_W-1:0]  bank_d [REG_CNT];
  logic [REG_CNT-1:0] wr_pulse_q, wr_pulse_d;

  logic [RD_ADDR_W-1:0] ar_idx;
  region_e              rd_region;
  logic                 ar_hs;
  logic [DATA_W-1:0]    rdata_sel;
  logic                 rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 unused_rd;

  taxi_axil_regfile_wr_join #(
    .REG_CNT (REG_CNT),
    .RO_CNT  (RO_CNT),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .STRB_W  (STRB_W)
  ) u_wr_join (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axil_wr     (s_axil_wr),
    .commit_o      (commit),
    .commit_idx_o  (commit_idx),
    .commit_data_o (commit_data),
    .commit_strb_o (commit_strb)
  );

  assign wr_region = decode_region(64'(commit_idx), REG_CNT, RO_CNT);

  // Byte-masked update of the addressed RW word plus its one-cycle pulse.
  always_comb begin
    bank_d     = bank_q;
    wr_pulse_d = '0;
    if (commit && wr_region == REGION_RW) begin
      for (int i = 0; i < REG_CNT; i++) begin
        if (64'(commit_idx) == 64'(i)) begin
          wr_pulse_d[i] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (commit_strb[b]) begin
              bank_d[i][b*8 +: 8] = commit_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Register bank and write pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the bank is a handful of architectural flops with a defined reset image, not a RAM, so it is reset.
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        bank_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
      end
      wr_pulse_q <= '0;
    end else begin
      bank_q     <= bank_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign ar_idx    = s_axil_rd.araddr >> SHIFT;
  assign rd_region = decode_region(64'(ar_idx), REG_CNT, RO_CNT);
  assign ar_hs     = s_axil_rd.arvalid && !rvalid_q;

  // Read mux: the bank value here is pre-commit, so a same-edge write is not seen.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      if (64'(ar_idx) == 64'(i)) rdata_sel = bank_q[i];
    end
    for (int j = 0; j < RO_CNT; j++) begin
      if (64'(ar_idx) == 64'(REG_CNT + j)) rdata_sel = ro_in[j*DATA_W +: DATA_W];
    end
  end

  // Next-state for the single-entry R slot.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (s_axil_rd.rready) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rdata_sel;
      rresp_d  = access_resp(rd_region, 1'b0);
    end
  end

  // Read response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_axil_rd.arready = !rvalid_q;
  assign s_axil_rd.rvalid  = rvalid_q;
  assign s_axil_rd.rdata   = rdata_q;
  assign s_axil_rd.rresp   = rresp_q;
  assign s_axil_rd.ruser   = '0;

  for (genvar g = 0; g < REG_CNT; g++) begin : g_reg_out
    assign reg_q[g*DATA_W +: DATA_W] = bank_q[g];
  end
  assign wr_pulse = wr_pulse_q;

  // Protection and user sidebands carry no meaning for this endpoint.
  assign unused_rd = ^{s_axil_rd.arprot, s_axil_rd.aruser};

endmodule
